uc1611_rx: RTL
==============

// Module: uc1611_rx
// PURPOSE
//  Responder end of the UC1611 8-bit parallel write bus: decodes command/data bytes from the LCD driver
//  and writes pixel bytes into a framebuffer RAM port. Models the subset of controller state the driver
//  uses (address counters, RAM address control, mapping, display enable, gray mode, gain/pot).
//  Sits between the driver's lcd_* outputs and a framebuffer used for simulation or video rescan.
// PARAMETERS
//  CA_MAX     239  last valid column address
//  PA_MAX     79   last valid page address
//  RST_HOLD   16   clk cycles after System Reset (0xE2) during which bytes are dropped
// PORTS
//  clk         in   1   system clock; all bus inputs sampled on posedge
//  reset       in   1   asynchronous, active-low reset
//  lcd_data    in   8   command/data byte
//  lcd_write   in   1   one-cycle write strobe; byte accepted when lcd_write && lcd_cs
//  lcd_cs      in   1   chip select, active high
//  lcd_cd      in   1   0 = command byte, 1 = display data byte
//  fb_we       out  1   framebuffer write enable, one-cycle pulse
//  fb_addr     out  15  {PA[6:0], CA[7:0]} of the byte being written
//  fb_data     out  8   pixel byte (low nibble = first pixel)
//  disp_en     out  3   DC[4:2] display enable
//  map_ctl     out  3   {MY, MX, MSF}
//  gray_mode   out  2   LC[6:5]
//  gain_pm     out  8   {GN[1:0], PM[5:0]}
//  frame_wrap  out  1   pulse: address wrapped back to the start of both ranges
//  bad_cmd     out  1   pulse: unknown opcode, dropped byte during reset hold, or out-of-range data write
// BEHAVIOUR
//  - All outputs registered. On reset: CA=0 PA=0 AC=3'b001, disp_en=0, map_ctl=0, gray_mode=0,
//    gain_pm=0, fb_we=0, fb_addr=0, fb_data=0, frame_wrap=0, bad_cmd=0, state=IDLE.
//  - FSM: IDLE, ARG (awaiting 0x81 operand), RSTWAIT (counting RST_HOLD).
//  - IDLE, cd=0 decode: 0x0n CA[3:0]=n; 0x1n CA[7:4]=n; 0x4n/0x5n scroll (accepted, discarded);
//    0x6n PA[3:0]=n; 0x70-77 PA[6:4]; 0x81 -> ARG; 0x84-87 partial (discarded); 0x88-8F AC=op[2:0];
//    0xA0-A3 line rate, 0x28-2B panel load, 0xE8-EB bias (discarded); 0xA8-AF disp_en=op[2:0];
//    0xC0-C7 map_ctl=op[2:0]; 0xD0-D3 gray_mode=op[1:0]; 0xE2 restore all reset values, -> RSTWAIT;
//    any other opcode -> bad_cmd pulse, no state change.
//  - ARG: next accepted byte (cd ignored) -> gain_pm; return to IDLE.
//  - RSTWAIT: accepted bytes dropped with bad_cmd pulse; after RST_HOLD cycles -> IDLE.
//  - IDLE, cd=1: if CA<=CA_MAX and PA<=PA_MAX: fb_we=1 next cycle with fb_addr={PA,CA}, fb_data=byte,
//    then advance; else bad_cmd, no write, address unchanged. Latency strobe->fb_we = 1 cycle.
//  - Advance, AC[1]=0 (column first): CA++; at CA==CA_MAX, CA=0 and, if AC[0], step PA.
//  - Advance, AC[1]=1 (page first): step PA; at PA end, PA=start and, if AC[0], CA++ (CA_MAX wraps to 0).
//  - Step PA: +1 wrapping PA_MAX->0 if AC[2]=0; -1 wrapping 0->PA_MAX if AC[2]=1.
//  - frame_wrap pulses with the fb_we whose advance returns both CA and PA to their start values.
//  - Strobes with lcd_cs=0 ignored entirely. Back-to-back strobes every cycle supported.
//  - Async reset mid-command (in ARG or RSTWAIT) returns to IDLE with reset values; no write emitted.
// TESTING
//  1. Bytes 0x8B,0x60,0x70,0x00,0x13 (cd=0) then 3 data bytes 0x11,0x22,0x33 -> fb_addr 0x0030,0x0130,0x0230.
//  2. AC=0x89, CA=CA_MAX, PA=5, two data bytes -> writes at {5,239} then {6,0}.
//  3. AC=0x8B, PA=PA_MAX, CA=CA_MAX, one data byte -> write, frame_wrap=1, next write at {0,0}.
//  4. 0x81 then 0x46 -> gain_pm=0x46; 0xAF -> disp_en=3'b111; 0xC6 -> map_ctl=3'b110.
//  5. 0xE2 then data byte next cycle -> bad_cmd=1, no fb_we; after RST_HOLD, CA=PA=0, AC=001.
//  6. Opcode 0xFF -> bad_cmd pulse; data with PA=0x7F -> bad_cmd, no fb_we; lcd_cs=0 strobe -> nothing.

Source files
------------

// File: rtl/uc1611_rx_if.sv
// UC1611 8-bit parallel write bus together with the framebuffer write port it produces.
// The master side is the LCD driver; the slave side is the uc1611_rx responder.
interface uc1611_rx_if;
    logic [7:0]  lcd_data;
    logic        lcd_write;
    logic        lcd_cs;
    logic        lcd_cd;
    logic        fb_we;
    logic [14:0] fb_addr;
    logic [7:0]  fb_data;

    modport master (
        output lcd_data, lcd_write, lcd_cs, lcd_cd,
        input  fb_we, fb_addr, fb_data
    );

    modport slave (
        input  lcd_data, lcd_write, lcd_cs, lcd_cd,
        output fb_we, fb_addr, fb_data
    );
endinterface

// File: rtl/uc1611_rx.sv
// UC1611 write-bus responder: decodes command bytes into controller state and turns
// display data bytes into single-cycle framebuffer writes with auto-advancing addresses.
module uc1611_rx #(
    parameter int CA_MAX   = 239,
    parameter int PA_MAX   = 79,
    parameter int RST_HOLD = 16
) (
    input  logic       clk_i,
    input  logic       reset_ni,
    uc1611_rx_if.slave bus,
    output logic [2:0] disp_en_o,
    output logic [2:0] map_ctl_o,
    output logic [1:0] gray_mode_o,
    output logic [7:0] gain_pm_o,
    output logic       frame_wrap_o,
    output logic       bad_cmd_o
);
    localparam int          HW      = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam logic [7:0]  CA_LAST = 8'(CA_MAX);
    localparam logic [6:0]  PA_LAST = 7'(PA_MAX);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(RST_HOLD - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_ARG     = 2'b01,
        ST_RSTWAIT = 2'b10
    } state_e;

    state_e        state_q;
    logic [7:0]    ca_q;
    logic [6:0]    pa_q;
    logic [2:0]    ac_q;
    logic [HW-1:0] hold_q;
    logic [2:0]    disp_en_q;
    logic [2:0]    map_ctl_q;
    logic [1:0]    gray_mode_q;
    logic [7:0]    gain_pm_q;
    logic          fb_we_q;
    logic [14:0]   fb_addr_q;
    logic [7:0]    fb_data_q;
    logic          frame_wrap_q;
    logic          bad_cmd_q;

    logic          accept_s;
    logic          cd_s;
    logic [7:0]    byte_s;
    logic          in_range_s;
    logic [6:0]    pa_start_s;
    logic [6:0]    pa_end_s;
    logic [7:0]    ca_d;
    logic [6:0]    pa_d;
    logic          wrap_d;

    function automatic logic [7:0] ca_step(input logic [7:0] ca);
        logic [7:0] r;
        if (ca == CA_LAST) begin
            r = 8'd0;
        end else begin
            r = ca + 8'd1;
        end
        return r;
    endfunction

    // Page step wraps at either end depending on the direction bit
    function automatic logic [6:0] pa_step(input logic [6:0] pa, input logic down);
        logic [6:0] r;
        if (down) begin
            if (pa == 7'd0) begin
                r = PA_LAST;
            end else begin
                r = pa - 7'd1;
            end
        end else begin
            if (pa == PA_LAST) begin
                r = 7'd0;
            end else begin
                r = pa + 7'd1;
            end
        end
        return r;
    endfunction

    assign accept_s   = bus.lcd_write && bus.lcd_cs;
    assign cd_s       = bus.lcd_cd;
    assign byte_s     = bus.lcd_data;
    assign in_range_s = (ca_q <= CA_LAST) && (pa_q <= PA_LAST);

    // Next address after a data write and whether it lands back on the frame origin
    always_comb begin
        pa_start_s = ac_q[2] ? PA_LAST : 7'd0;
        pa_end_s   = ac_q[2] ? 7'd0 : PA_LAST;
        ca_d       = ca_q;
        pa_d       = pa_q;
        if (ac_q[1]) begin
            pa_d = pa_step(pa_q, ac_q[2]);
            if (ac_q[0] && (pa_q == pa_end_s)) begin
                ca_d = ca_step(ca_q);
            end else begin
                ca_d = ca_q;
            end
        end else begin
            ca_d = ca_step(ca_q);
            if (ac_q[0] && (ca_q == CA_LAST)) begin
                pa_d = pa_step(pa_q, ac_q[2]);
            end else begin
                pa_d = pa_q;
            end
        end
        wrap_d = (ca_d == 8'd0) && (pa_d == pa_start_s);
    end

    // Controller FSM: command decode, data writes, operand capture and reset hold-off
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q      <= ST_IDLE;
            ca_q         <= 8'd0;
            pa_q         <= 7'd0;
            ac_q         <= 3'b001;
            hold_q       <= '0;
            disp_en_q    <= 3'd0;
            map_ctl_q    <= 3'd0;
            gray_mode_q  <= 2'd0;
            gain_pm_q    <= 8'd0;
            fb_we_q      <= 1'b0;
            fb_addr_q    <= 15'd0;
            fb_data_q    <= 8'd0;
            frame_wrap_q <= 1'b0;
            bad_cmd_q    <= 1'b0;
        end else begin
            fb_we_q      <= 1'b0;
            frame_wrap_q <= 1'b0;
            bad_cmd_q    <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept_s && cd_s) begin
                        if (in_range_s) begin
                            fb_we_q      <= 1'b1;
                            fb_addr_q    <= {pa_q, ca_q};
                            fb_data_q    <= byte_s;
                            frame_wrap_q <= wrap_d;
                            ca_q         <= ca_d;
                            pa_q         <= pa_d;
                        end else begin
                            bad_cmd_q <= 1'b1;
                        end
                    end else if (accept_s) begin
                        casez (byte_s)
                            8'b0000_????: ca_q[3:0]   <= byte_s[3:0];
                            8'b0001_????: ca_q[7:4]   <= byte_s[3:0];
                            8'b0110_????: pa_q[3:0]   <= byte_s[3:0];
                            8'b0111_0???: pa_q[6:4]   <= byte_s[2:0];
                            8'b1000_0001: state_q     <= ST_ARG;
                            8'b1000_1???: ac_q        <= byte_s[2:0];
                            8'b1010_1???: disp_en_q   <= byte_s[2:0];
                            8'b1100_0???: map_ctl_q   <= byte_s[2:0];
                            8'b1101_00??: gray_mode_q <= byte_s[1:0];
                            8'b1110_0010: begin
                                ca_q        <= 8'd0;
                                pa_q        <= 7'd0;
                                ac_q        <= 3'b001;
                                disp_en_q   <= 3'd0;
                                map_ctl_q   <= 3'd0;
                                gray_mode_q <= 2'd0;
                                gain_pm_q   <= 8'd0;
                                hold_q      <= HOLD_LOAD;
                                state_q     <= ST_RSTWAIT;
                            end
                            // Scroll, panel load, partial display, line rate and bias: accepted, no effect here
                            8'b0010_10??, 8'b010?_????, 8'b1000_01??,
                            8'b1010_00??, 8'b1110_10??: begin
                            end
                            default: bad_cmd_q <= 1'b1;
                        endcase
                    end
                end
                ST_ARG: begin
                    if (accept_s) begin
                        gain_pm_q <= byte_s;
                        state_q   <= ST_IDLE;
                    end
                end
                ST_RSTWAIT: begin
                    if (accept_s) begin
                        bad_cmd_q <= 1'b1;
                    end
                    if (hold_q == '0) begin
                        state_q <= ST_IDLE;
                    end else begin
                        hold_q <= hold_q - HW'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.fb_we     = fb_we_q;
    assign bus.fb_addr   = fb_addr_q;
    assign bus.fb_data   = fb_data_q;
    assign disp_en_o     = disp_en_q;
    assign map_ctl_o     = map_ctl_q;
    assign gray_mode_o   = gray_mode_q;
    assign gain_pm_o     = gain_pm_q;
    assign frame_wrap_o  = frame_wrap_q;
    assign bad_cmd_o     = bad_cmd_q;
endmodule
